// File: rtl/capture_controller.sv
// Capture/dump sequencer for the ADC sampler: drives the IAGC status code and
// decimated sample strobe, supervises end-of-capture, then streams both banks out.
module capture_controller #(
    parameter int ADDR_SIZE        = 12,
    parameter int DEC_SIZE         = 16,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int END_TIMEOUT      = 8
) (
    input  logic                        i_clock,
    input  logic                        i_resetn,
    input  logic                        i_start,
    input  logic                        i_dump,
    input  logic                        i_abort,
    input  logic [DEC_SIZE-1:0]         i_decimation,
    input  logic [ADDR_SIZE-1:0]        i_memory_size,
    input  logic                        i_sampler_end,
    input  logic                        i_rd_ready,
    output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status,
    output logic                        o_sample,
    output logic [ADDR_SIZE-1:0]        o_rd_addr,
    output logic                        o_rd_sel,
    output logic                        o_rd_valid,
    output logic                        o_busy,
    output logic                        o_capture_valid
);

    localparam int TO_W = $clog2(END_TIMEOUT + 1);

    localparam logic [IAGC_STATUS_SIZE-1:0] STAT_RST      = IAGC_STATUS_SIZE'(0);
    localparam logic [IAGC_STATUS_SIZE-1:0] STAT_IDLE     = IAGC_STATUS_SIZE'(2);
    localparam logic [IAGC_STATUS_SIZE-1:0] STAT_SAMPLE   = IAGC_STATUS_SIZE'(3);
    localparam logic [IAGC_STATUS_SIZE-1:0] STAT_ERROR    = IAGC_STATUS_SIZE'(6);
    localparam logic [IAGC_STATUS_SIZE-1:0] STAT_DUMP_REF = IAGC_STATUS_SIZE'(7);
    localparam logic [IAGC_STATUS_SIZE-1:0] STAT_DUMP_ERR = IAGC_STATUS_SIZE'(8);

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_SAMPLE,
        ST_WAIT_END,
        ST_CMD_ERROR,
        ST_DUMP_REF,
        ST_DUMP_ERR
    } state_t;

    state_t state, state_d;

    logic [DEC_SIZE-1:0]         dec_q, dec_d;
    logic [DEC_SIZE-1:0]         dec_cnt, dec_cnt_d;
    logic [ADDR_SIZE-1:0]        mem_q, mem_d;
    logic [ADDR_SIZE:0]          strobe_cnt, strobe_cnt_d, strobe_inc;
    logic [ADDR_SIZE:0]          rd_cnt, rd_cnt_d, mem_last;
    logic [TO_W-1:0]             timeout_cnt, timeout_cnt_d;
    logic [IAGC_STATUS_SIZE-1:0] status_d;
    logic                        sample_d, rd_valid_d, rd_sel_d, busy_d, capture_valid_d;

    // Counters are one bit wider than the address so a full-size capture never wraps.
    assign mem_last   = {1'b0, mem_q} - {{ADDR_SIZE{1'b0}}, 1'b1};
    assign strobe_inc = strobe_cnt + 1'b1;
    assign o_rd_addr  = rd_cnt[ADDR_SIZE-1:0];

    always_comb begin
        state_d         = state;
        dec_d           = dec_q;
        mem_d           = mem_q;
        dec_cnt_d       = dec_cnt;
        strobe_cnt_d    = strobe_cnt;
        rd_cnt_d        = rd_cnt;
        timeout_cnt_d   = timeout_cnt;
        capture_valid_d = o_capture_valid;

        if (i_abort) begin
            state_d         = ST_RST;
            capture_valid_d = 1'b0;
            rd_cnt_d        = '0;
        end else begin
            case (state)
                ST_RST: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_memory_size == '0) begin
                            state_d = ST_CMD_ERROR;
                        end else begin
                            state_d         = ST_SAMPLE;
                            dec_d           = i_decimation;
                            mem_d           = i_memory_size;
                            dec_cnt_d       = '0;
                            strobe_cnt_d    = '0;
                            capture_valid_d = 1'b0;
                        end
                    end else if (i_dump) begin
                        if (o_capture_valid) begin
                            state_d  = ST_DUMP_REF;
                            rd_cnt_d = '0;
                        end else begin
                            state_d = ST_CMD_ERROR;
                        end
                    end
                end
                ST_SAMPLE: begin
                    if (dec_cnt == dec_q) begin
                        dec_cnt_d    = '0;
                        strobe_cnt_d = strobe_inc;
                        if (strobe_inc == {1'b0, mem_q}) begin
                            state_d       = ST_WAIT_END;
                            timeout_cnt_d = '0;
                        end
                    end else begin
                        dec_cnt_d = dec_cnt + 1'b1;
                    end
                end
                // Status stays at SAMPLE here so the sampler can finish its last write.
                ST_WAIT_END: begin
                    if (i_sampler_end) begin
                        state_d         = ST_IDLE;
                        capture_valid_d = 1'b1;
                    end else if (timeout_cnt == TO_W'(END_TIMEOUT - 1)) begin
                        state_d = ST_CMD_ERROR;
                    end else begin
                        timeout_cnt_d = timeout_cnt + 1'b1;
                    end
                end
                ST_CMD_ERROR: state_d = ST_IDLE;
                ST_DUMP_REF, ST_DUMP_ERR: begin
                    if (o_rd_valid && i_rd_ready) begin
                        if (rd_cnt == mem_last) begin
                            rd_cnt_d = '0;
                            state_d  = (state == ST_DUMP_REF) ? ST_DUMP_ERR : ST_IDLE;
                        end else begin
                            rd_cnt_d = rd_cnt + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        sample_d   = (state_d == ST_SAMPLE) && (dec_cnt_d == dec_d);
        rd_valid_d = (state_d == ST_DUMP_REF) || (state_d == ST_DUMP_ERR);
        rd_sel_d   = (state_d == ST_DUMP_ERR);
        busy_d     = (state_d != ST_IDLE);

        case (state_d)
            ST_RST:       status_d = STAT_RST;
            ST_IDLE:      status_d = STAT_IDLE;
            ST_SAMPLE:    status_d = STAT_SAMPLE;
            ST_WAIT_END:  status_d = STAT_SAMPLE;
            ST_CMD_ERROR: status_d = STAT_ERROR;
            ST_DUMP_REF:  status_d = STAT_DUMP_REF;
            ST_DUMP_ERR:  status_d = STAT_DUMP_ERR;
            default:      status_d = STAT_RST;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state           <= ST_RST;
            dec_q           <= '0;
            mem_q           <= '0;
            dec_cnt         <= '0;
            strobe_cnt      <= '0;
            rd_cnt          <= '0;
            timeout_cnt     <= '0;
            o_iagc_status   <= STAT_RST;
            o_sample        <= 1'b0;
            o_rd_sel        <= 1'b0;
            o_rd_valid      <= 1'b0;
            o_busy          <= 1'b1;
            o_capture_valid <= 1'b0;
        end else begin
            state           <= state_d;
            dec_q           <= dec_d;
            mem_q           <= mem_d;
            dec_cnt         <= dec_cnt_d;
            strobe_cnt      <= strobe_cnt_d;
            rd_cnt          <= rd_cnt_d;
            timeout_cnt     <= timeout_cnt_d;
            o_iagc_status   <= status_d;
            o_sample        <= sample_d;
            o_rd_sel        <= rd_sel_d;
            o_rd_valid      <= rd_valid_d;
            o_busy          <= busy_d;
            o_capture_valid <= capture_valid_d;
        end
    end

endmodule

// File: doc/capture_controller.md
Name: capture_controller

Overview:
Sequencer for one capture/dump cycle of the ADC sampler. It drives the sampler's IAGC status code and sample strobe, and applies a programmable decimation. It supervises end-of-capture and then streams stored reference and error samples out through a valid/ready read-address interface. It sits between the command parser and the adc_sampler / sample BRAM pair.

Parameters:
ADDR_SIZE, 12, sample memory address width
DEC_SIZE, 16, decimation count width
IAGC_STATUS_SIZE, 4, status code width
END_TIMEOUT, 8, max cycles from last strobe to i_sampler_end before error

Ports:
i_clock  in  1  system clock
i_resetn  in  1  reset; asynchronous, active-low
i_start  in  1  1-cycle pulse; begin capture
i_dump  in  1  1-cycle pulse; stream stored capture
i_abort  in  1  level; abandon any operation
i_decimation  in  DEC_SIZE  strobe period minus 1; sampled on accepted i_start
i_memory_size  in  ADDR_SIZE  samples per capture; sampled on accepted i_start
i_sampler_end  in  1  sampler end-of-capture flag
i_rd_ready  in  1  downstream accepts current read address
o_iagc_status  out  IAGC_STATUS_SIZE  status code to sampler/host
o_sample  out  1  sample strobe to sampler
o_rd_addr  out  ADDR_SIZE  memory read address
o_rd_sel  out  1  0 = reference bank, 1 = error bank
o_rd_valid  out  1  o_rd_addr/o_rd_sel valid
o_busy  out  1  state not IDLE
o_capture_valid  out  1  a complete capture is stored

Behaviour:
- All outputs registered. Async reset sets:
  - state RST
  - o_iagc_status 4'b0000, o_sample 0, o_rd_addr 0, o_rd_sel 0, o_rd_valid 0, o_busy 1, o_capture_valid 0
  - latched dec/mem_size 0, all counters 0
- States and status codes:
  - RST 0000, held exactly one cycle, then IDLE
  - IDLE 0010
  - SAMPLE 0011
  - WAIT_END 0011
  - CMD_ERROR 0110, held one cycle, then IDLE
  - DUMP_REF 0111
  - DUMP_ERR 1000
- IDLE:
  - i_start with i_memory_size != 0: latch dec and mem_size, clear o_capture_valid, clear strobe and decimation counters, go to SAMPLE.
  - i_start with i_memory_size == 0: go to CMD_ERROR.
  - i_dump with o_capture_valid = 1: go to DUMP_REF, rd_addr 0.
  - i_dump with o_capture_valid = 0: go to CMD_ERROR.
  - i_start and i_dump in the same cycle: start wins.
- SAMPLE:
  - Decimation counter runs 0..dec; o_sample = 1 in the cycle the counter equals dec, then the counter wraps to 0.
  - First strobe occurs dec+1 cycles after SAMPLE entry. dec = 0 gives a strobe every cycle.
  - Strobe count increments per strobe. When it reaches mem_size, go to WAIT_END with o_sample 0 and the timeout counter cleared.
  - Exactly mem_size strobes per capture.
- WAIT_END:
  - No strobes.
  - i_sampler_end = 1: o_capture_valid <= 1, go to IDLE.
  - Timeout counter reaches END_TIMEOUT without i_sampler_end: go to CMD_ERROR, o_capture_valid stays 0.
  - Status remains 0011 so the sampler finishes its write.
  - Leaving WAIT_END on i_sampler_end prevents sampler re-arm, because the sampler sees IDLE when it returns to INIT.
- DUMP_REF / DUMP_ERR:
  - o_rd_valid = 1; o_rd_sel = 0 in DUMP_REF, 1 in DUMP_ERR.
  - While o_rd_valid & !i_rd_ready, o_rd_addr and o_rd_sel hold stable.
  - On a handshake (valid & ready):
    - addr < mem_size-1: addr+1.
    - addr == mem_size-1 in DUMP_REF: go to DUMP_ERR, addr 0.
    - addr == mem_size-1 in DUMP_ERR: o_rd_valid 0, go to IDLE.
  - Back-to-back handshakes: one address per cycle.
  - o_capture_valid stays 1 after a dump, so the capture can be re-dumped.
- i_start / i_dump outside IDLE are ignored.
- i_abort = 1 in any state:
  - next state RST; o_sample 0, o_rd_valid 0, o_capture_valid 0.
  - RST is re-entered every cycle while i_abort is held.
- Counter widths: strobe and rd_addr counters are ADDR_SIZE+1 wide, so mem_size = 2^ADDR_SIZE-1 does not wrap. The decimation counter is DEC_SIZE.
- o_busy = (state != IDLE).

Test Plan:
- Reset release: o_iagc_status 0000 for one cycle, then 0010; o_busy 1→0; all other outputs 0.
- Start, dec=3, mem_size=5: exactly 5 strobes, each 4 cycles apart, the first in the 4th cycle after SAMPLE entry; i_sampler_end 2 cycles after the last strobe → status 0010, o_capture_valid 1.
- Dump, mem_size=5, i_rd_ready toggling 1,0,1,…: ref addresses 0..4 with o_rd_sel 0, then err addresses 0..4 with o_rd_sel 1; each address held while ready=0; exactly 10 handshakes, then IDLE.
- Fault cases:
  - i_dump before any capture → one cycle of 0110, then 0010.
  - i_start with mem_size=0 → 0110, no strobes.
  - i_sampler_end withheld → 0110 after END_TIMEOUT cycles, o_capture_valid 0.
- i_start and i_dump in the same IDLE cycle → SAMPLE entered, no o_rd_valid.
- i_abort mid-SAMPLE (after 2 of 5 strobes) and mid-DUMP_ERR → next cycle status 0000, o_sample/o_rd_valid 0, o_capture_valid 0, then IDLE; i_resetn low mid-dump → immediate reset values.
